rx_packet_deserializer: RTL

Receive-path stage directly downstream of the bit unstuffer in the Serial Interface Engine. Consumes the unstuffed, NRZI-decoded serial bit stream, hunts for SYNC, assembles LSB-first bytes, validates the PID, and frames the packet on EOP. It presents parallel bytes with single-cycle strobes to the packet decoder (PID/CRC checker) above it.

---
 rtl/sie_pkg.sv | 36 +++
 rtl/rx_sync_detect.sv | 50 +++++
 rtl/rx_packet_deserializer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/sie_pkg.sv
// Shared definitions for the Serial Interface Engine receive path.
// Contents:
//   rx_state_e        - deserializer FSM states
//   SYNC_PATTERN      - SYNC as it appears in the right-shifting bit history
//   PID_*             - PID[3:0] nibble values of the standard token/data/handshake PIDs
//   MAX_BYTES_DEFAULT - PID + 1023 data bytes + 2 CRC16 bytes
//   pid_check_ok()    - PID check-nibble test (upper nibble is the complement of the lower)
package sie_pkg;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_PID   = 2'd1,
    ST_DATA  = 2'd2,
    ST_ABORT = 2'd3
  } rx_state_e;

  // Oldest bit sits in bit 0, newest in bit 7: seven zeros followed by a one.
  localparam logic [7:0] SYNC_PATTERN = 8'h80;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  localparam int MAX_BYTES_DEFAULT = 1026;

  function automatic logic pid_check_ok(input logic [7:0] pid_byte);
    return (pid_byte[7:4] == ~pid_byte[3:0]);
  endfunction

endpackage

// File: rtl/rx_sync_detect.sv
// SYNC hunter: keeps an 8-bit history of valid bits and flags the bit that
// completes the SYNC sequence.
// Ports:
//   clk     - system clock
//   rst     - asynchronous active-low reset
//   clear_i - hold the history at zero (asserted whenever the FSM is not hunting)
//   shift_i - data_i is a real bit to be shifted into the history this cycle
//   data_i  - serial bit
//   match_o - combinational: the bit being shifted in now completes SYNC
module rx_sync_detect
  import sie_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic shift_i,
  input  logic data_i,
  output logic match_o
);

  logic [7:0] hist_q;
  logic [7:0] hist_d;
  logic [7:0] hist_shift_s;

  // New bits enter at the top so the history reads oldest-first from bit 0.
  assign hist_shift_s = {data_i, hist_q[7:1]};
  assign match_o      = shift_i & (hist_shift_s == SYNC_PATTERN);

  // Next-state history: clear while not hunting so every hunt starts from zero.
  always_comb begin
    hist_d = hist_q;
    if (clear_i) begin
      hist_d = 8'h00;
    end else if (shift_i) begin
      hist_d = hist_shift_s;
    end else begin
      hist_d = hist_q;
    end
  end

  // History register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= 8'h00;
    end else begin
      hist_q <= hist_d;
    end
  end

endmodule

// File: rtl/rx_packet_deserializer.sv
// Receive-path packet deserializer: hunts SYNC, assembles LSB-first bytes,
// validates the PID and frames the packet on EOP. All outputs registered.
// Ports:
//   clk, rst             - clock, asynchronous active-low reset
//   data_in, bit_valid   - unstuffed serial bit and its qualifier
//   eop                  - single-cycle end-of-packet indication
//   rx_byte/_valid       - last assembled byte (held) and its one-cycle strobe
//   pid/pid_valid        - PID[3:0] of current packet and its strobe
//   pid_err              - strobe: PID check nibble mismatch (packet aborted)
//   rx_active            - high from SYNC match until packet end
//   rx_done              - strobe: packet ended by eop (not after an abort)
//   byte_err             - strobe: eop off byte boundary, or byte overflow
//   byte_count           - bytes received in current/last packet, PID included
module rx_packet_deserializer
  import sie_pkg::*;
#(
  parameter int MAX_BYTES = MAX_BYTES_DEFAULT,
  parameter int CNT_W     = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in,
  input  logic             bit_valid,
  input  logic             eop,
  output logic [7:0]       rx_byte,
  output logic             rx_byte_valid,
  output logic [3:0]       pid,
  output logic             pid_valid,
  output logic             pid_err,
  output logic             rx_active,
  output logic             rx_done,
  output logic             byte_err,
  output logic [CNT_W-1:0] byte_count
);

  rx_state_e        state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             rx_byte_valid_q, rx_byte_valid_d;
  logic [3:0]       pid_q, pid_d;
  logic             pid_valid_q, pid_valid_d;
  logic             pid_err_q, pid_err_d;
  logic             rx_active_q, rx_active_d;
  logic             rx_done_q, rx_done_d;
  logic             byte_err_q, byte_err_d;
  logic [CNT_W-1:0] byte_count_q, byte_count_d;

  logic       sync_match_s;
  logic       hunt_shift_s;
  logic [7:0] byte_next_s;

  // A bit arriving together with eop is discarded, including during the hunt.
  assign hunt_shift_s = (state_q == ST_HUNT) & bit_valid & ~eop;
  assign byte_next_s  = {data_in, shreg_q[7:1]};

  rx_sync_detect u_sync (
    .clk     (clk),
    .rst     (rst),
    .clear_i (state_q != ST_HUNT),
    .shift_i (hunt_shift_s),
    .data_i  (data_in),
    .match_o (sync_match_s)
  );

  // FSM next state, byte assembly and next values of all registered outputs.
  always_comb begin
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    shreg_d         = shreg_q;
    rx_byte_d       = rx_byte_q;
    pid_d           = pid_q;
    rx_active_d     = rx_active_q;
    byte_count_d    = byte_count_q;
    rx_byte_valid_d = 1'b0;
    pid_valid_d     = 1'b0;
    pid_err_d       = 1'b0;
    rx_done_d       = 1'b0;
    byte_err_d      = 1'b0;

    case (state_q)
      ST_HUNT: begin
        if (sync_match_s) begin
          state_d      = ST_PID;
          rx_active_d  = 1'b1;
          bit_cnt_d    = 3'd0;
          byte_count_d = {CNT_W{1'b0}};
        end else begin
          state_d = ST_HUNT;
        end
      end

      ST_PID, ST_DATA: begin
        if (eop) begin
          // A non-zero bit counter means a partial byte is being dropped.
          rx_done_d   = 1'b1;
          byte_err_d  = (bit_cnt_q != 3'd0);
          rx_active_d = 1'b0;
          bit_cnt_d   = 3'd0;
          state_d     = ST_HUNT;
        end else if (bit_valid) begin
          shreg_d   = byte_next_s;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (state_q == ST_PID) begin
              rx_byte_d       = byte_next_s;
              rx_byte_valid_d = 1'b1;
              pid_d           = byte_next_s[3:0];
              pid_valid_d     = 1'b1;
              byte_count_d    = byte_count_q + CNT_W'(1);
              if (pid_check_ok(byte_next_s)) begin
                state_d = ST_DATA;
              end else begin
                pid_err_d = 1'b1;
                state_d   = ST_ABORT;
              end
            end else if (byte_count_q == CNT_W'(MAX_BYTES)) begin
              // One byte too many: withhold it and abandon the packet.
              byte_err_d = 1'b1;
              state_d    = ST_ABORT;
            end else begin
              rx_byte_d       = byte_next_s;
              rx_byte_valid_d = 1'b1;
              byte_count_d    = byte_count_q + CNT_W'(1);
            end
          end else begin
            state_d = state_q;
          end
        end else begin
          state_d = state_q;
        end
      end

      ST_ABORT: begin
        if (eop) begin
          rx_active_d = 1'b0;
          bit_cnt_d   = 3'd0;
          state_d     = ST_HUNT;
        end else begin
          state_d = ST_ABORT;
        end
      end

      default: begin
        rx_active_d = 1'b0;
        bit_cnt_d   = 3'd0;
        state_d     = ST_HUNT;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_HUNT;
      bit_cnt_q       <= 3'd0;
      shreg_q         <= 8'h00;
      rx_byte_q       <= 8'h00;
      rx_byte_valid_q <= 1'b0;
      pid_q           <= 4'h0;
      pid_valid_q     <= 1'b0;
      pid_err_q       <= 1'b0;
      rx_active_q     <= 1'b0;
      rx_done_q       <= 1'b0;
      byte_err_q      <= 1'b0;
      byte_count_q    <= {CNT_W{1'b0}};
    end else begin
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      shreg_q         <= shreg_d;
      rx_byte_q       <= rx_byte_d;
      rx_byte_valid_q <= rx_byte_valid_d;
      pid_q           <= pid_d;
      pid_valid_q     <= pid_valid_d;
      pid_err_q       <= pid_err_d;
      rx_active_q     <= rx_active_d;
      rx_done_q       <= rx_done_d;
      byte_err_q      <= byte_err_d;
      byte_count_q    <= byte_count_d;
    end
  end

  assign rx_byte       = rx_byte_q;
  assign rx_byte_valid = rx_byte_valid_q;
  assign pid           = pid_q;
  assign pid_valid     = pid_valid_q;
  assign pid_err       = pid_err_q;
  assign rx_active     = rx_active_q;
  assign rx_done       = rx_done_q;
  assign byte_err      = byte_err_q;
  assign byte_count    = byte_count_q;

endmodule
